dsp_top: RTL and testbench
==========================

DSP_TOP -- requirements
Module: dsp_top

Interface
REQ-001 Parameters:
- datainwidth, 18, width of A/B/D/BCIN/BCOUT.
- dataoutwidth, 48, width of C/PCIN/P/PCOUT.
- opwidth, 8, OPMODE width.
- DREG, CREG, A1REG, B1REG, MREG, PREG, CARRYINREG, CARRYOUTREG, OPMODEREG, 1 each; 1 = registered stage, 0 = combinational bypass.
- CARRYINSEL, "OPMODE5"; carry source, "OPMODE5" or "CARRYIN".
- B_INPUT, "DIRECT"; B source, "DIRECT" (b) or "CASCADE" (bcin).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all registers update on rising edge.
- rsta, rstb, rstm, rstp, rstc, rstd, rstcarryin, rstopmode, in, 1 each, per-stage reset; synchronous, active-high.
- cea, ceb, cem, cep, cec, ced, cecarryin, ceopmode, in, 1 each, per-stage clock enable, active-high.
- d, in, 18, pre-adder operand.
- b, in, 18, direct B operand.
- bcin, in, 18, cascaded B operand.
- a, in, 18, multiplier operand.
- c, in, 48, post-adder Z operand.
- pcin, in, 48, cascaded P input.
- carryin, in, 1, external carry.
- opmode, in, 8, operation select.
- m, out, 36, multiplier stage output.
- p, out, 48, result.
- pcout, out, 48, copy of p.
- bcout, out, 18, B1 stage output.
- carryout, out, 1, post-adder carry.
- carryoutf, out, 1, copy of carryout.

Function
REQ-003 The opmode stage SHALL feed every select below (registered per OPMODEREG).
REQ-004 Pre-adder: opmode[6]=0 -> D+B0; opmode[6]=1 -> D-B0; result is 18-bit, wraps modulo 2^18.
REQ-005 B1 input SHALL be the pre-adder result when opmode[4]=1, else B0 (b or bcin per B_INPUT).
REQ-006 Multiplier: M = A1*B1, 36-bit unsigned, never overflows; m carries the M stage output.
REQ-007 X mux on opmode[1:0]: 0 -> 0; 1 -> M zero-extended; 2 -> P; 3 -> {D[11:0],A1,B1}.
REQ-008 Z mux on opmode[3:2]: 0 -> 0; 1 -> pcin; 2 -> P; 3 -> C.
REQ-009 CIN: opmode[5] when CARRYINSEL="OPMODE5", else carryin; passes through the carry-in stage.
REQ-010 Post-adder: 49-bit computation; opmode[7]=0 -> Z+X+CIN; opmode[7]=1 -> Z-(X+CIN). Low 48 bits go to P; bit 48 goes to carryout.
REQ-011 pcout SHALL equal p and carryoutf SHALL equal carryout at all times.
REQ-012 With all defaults, latency is 3 clocks a->p (A1, M, P) and 4 clocks d->p (D, B1, M, P).
REQ-013 A stage with CE low SHALL hold its value; P feedback SHALL accumulate once per enabled edge.

Reset
REQ-014 Each register SHALL clear to 0 on a rising edge while its rst is high; reset has priority over CE.
REQ-015 Reset mapping: rsta -> A1; rstb -> B1; rstd -> D; rstc -> C; rstm -> M; rstp -> P; rstcarryin -> CIN and CYO; rstopmode -> opmode.
REQ-016 When the relevant stages are reset, p, pcout, m, bcout, carryout and carryoutf SHALL read 0.

Configuration
REQ-017 With DSP_TOP_BCIN_CASCADE_EN defined, B_INPUT selects b or bcin. Without it, bcin is ignored and b is always used.

Structure
REQ-018 Shared package dsp_top_pkg SHALL hold the width constants and the opmode bit-index/mux-code constants.
REQ-019 A single sub-module, dsp_reg_mux, SHALL implement one stage: parameterized width, enable, CE, sync reset, and register-or-bypass mux. It is instantiated for every stage.

Verification
All scenarios use d=20, b=12, bcin=18, a=15, c=32, pcin=48, carryin=1, all CE=1, all rst=0, default parameters.
REQ-020 opmode=8'hE0 -> m=180; p=48'hFFFF_FFFF_FFFF; carryout=1.
REQ-021 opmode=8'hF0 -> m=120 (pre-adder 20-12=8); p remains all ones.
REQ-022 opmode=8'h30 -> m=480 (20+12=32); p=1; carryout=0.
REQ-023 opmode=8'h35 -> p=529 (48+480+1).
REQ-024 opmode=8'h3A after p=529 -> p=1059, then 2119 on successive cycles; then opmode=8'h3F -> p=48'h0140_003C_0041.
REQ-025 Assert rstp and rstm for one edge mid-accumulation -> p=0 and m=0 on that edge; accumulation resumes the following cycle.

Source files
------------

// File: rtl/dsp_top_pkg.sv
// Shared constants for dsp_top: datapath widths, opmode bit positions and X/Z mux codes.
package dsp_top_pkg;

    localparam int DATAIN_W  = 18;
    localparam int DATAOUT_W = 48;
    localparam int OP_W      = 8;

    // opmode bit positions
    localparam int OP_X_LO     = 0;
    localparam int OP_X_HI     = 1;
    localparam int OP_Z_LO     = 2;
    localparam int OP_Z_HI     = 3;
    localparam int OP_B1_PRE   = 4;
    localparam int OP_CIN      = 5;
    localparam int OP_PRE_SUB  = 6;
    localparam int OP_POST_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

endpackage

// File: rtl/dsp_reg_mux.sv
// One pipeline stage: synchronous-reset, clock-enabled register with an optional
// combinational bypass selected by the enable parameter.
module dsp_reg_mux #(
    parameter int width  = 18,
    parameter int enable = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] q;

    // Reset wins over clock enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ce) begin
            q <= din;
        end
    end

    assign dout = (enable != 0) ? q : din;

endmodule

// File: rtl/dsp_top.sv
// DSP slice: pre-adder, multiplier, X/Z muxes and post-adder with optional pipeline stages.
// Define DSP_TOP_BCIN_CASCADE_EN to let B_INPUT pick bcin; otherwise b is always used.
module dsp_top
    import dsp_top_pkg::*;
#(
    parameter int    datainwidth  = DATAIN_W,
    parameter int    dataoutwidth = DATAOUT_W,
    parameter int    opwidth      = OP_W,
    parameter int    DREG         = 1,
    parameter int    CREG         = 1,
    parameter int    A1REG        = 1,
    parameter int    B1REG        = 1,
    parameter int    MREG         = 1,
    parameter int    PREG         = 1,
    parameter int    CARRYINREG   = 1,
    parameter int    CARRYOUTREG  = 1,
    parameter int    OPMODEREG    = 1,
    parameter string CARRYINSEL   = "OPMODE5",
    parameter string B_INPUT      = "DIRECT"
) (
    input  logic                        clk,
    input  logic                        rsta,
    input  logic                        rstb,
    input  logic                        rstm,
    input  logic                        rstp,
    input  logic                        rstc,
    input  logic                        rstd,
    input  logic                        rstcarryin,
    input  logic                        rstopmode,
    input  logic                        cea,
    input  logic                        ceb,
    input  logic                        cem,
    input  logic                        cep,
    input  logic                        cec,
    input  logic                        ced,
    input  logic                        cecarryin,
    input  logic                        ceopmode,
    input  logic [datainwidth-1:0]      d,
    input  logic [datainwidth-1:0]      b,
    input  logic [datainwidth-1:0]      bcin,
    input  logic [datainwidth-1:0]      a,
    input  logic [dataoutwidth-1:0]     c,
    input  logic [dataoutwidth-1:0]     pcin,
    input  logic                        carryin,
    input  logic [opwidth-1:0]          opmode,
    output logic [2*datainwidth-1:0]    m,
    output logic [dataoutwidth-1:0]     p,
    output logic [dataoutwidth-1:0]     pcout,
    output logic [datainwidth-1:0]      bcout,
    output logic                        carryout,
    output logic                        carryoutf
);

    localparam int mwidth = 2 * datainwidth;
    localparam int dhi    = dataoutwidth - mwidth;

    logic [opwidth-1:0]      opmode_q;
    logic [datainwidth-1:0]  d_q;
    logic [datainwidth-1:0]  a1_q;
    logic [datainwidth-1:0]  b0;
    logic [datainwidth-1:0]  pre;
    logic [datainwidth-1:0]  b1_d;
    logic [datainwidth-1:0]  b1_q;
    logic [dataoutwidth-1:0] c_q;
    logic [mwidth-1:0]       mult;
    logic [mwidth-1:0]       m_q;
    logic                    cin_src;
    logic                    cin_q;
    logic [dataoutwidth-1:0] xmux;
    logic [dataoutwidth-1:0] zmux;
    logic [dataoutwidth:0]   post;
    logic [dataoutwidth-1:0] p_q;
    logic                    cyo_q;

`ifdef DSP_TOP_BCIN_CASCADE_EN
    assign b0 = (B_INPUT == "CASCADE") ? bcin : b;
`else
    logic unused_bcin;
    assign b0          = b;
    assign unused_bcin = ^bcin;
`endif

    dsp_reg_mux #(.width(opwidth), .enable(OPMODEREG)) u_opmode (
        .clk(clk), .rst(rstopmode), .ce(ceopmode), .din(opmode), .dout(opmode_q)
    );

    dsp_reg_mux #(.width(datainwidth), .enable(DREG)) u_dreg (
        .clk(clk), .rst(rstd), .ce(ced), .din(d), .dout(d_q)
    );

    dsp_reg_mux #(.width(datainwidth), .enable(A1REG)) u_a1reg (
        .clk(clk), .rst(rsta), .ce(cea), .din(a), .dout(a1_q)
    );

    dsp_reg_mux #(.width(dataoutwidth), .enable(CREG)) u_creg (
        .clk(clk), .rst(rstc), .ce(cec), .din(c), .dout(c_q)
    );

    // Pre-adder wraps at datainwidth bits.
    assign pre  = opmode_q[OP_PRE_SUB] ? (d_q - b0) : (d_q + b0);
    assign b1_d = opmode_q[OP_B1_PRE] ? pre : b0;

    dsp_reg_mux #(.width(datainwidth), .enable(B1REG)) u_b1reg (
        .clk(clk), .rst(rstb), .ce(ceb), .din(b1_d), .dout(b1_q)
    );

    assign mult = mwidth'(a1_q) * mwidth'(b1_q);

    dsp_reg_mux #(.width(mwidth), .enable(MREG)) u_mreg (
        .clk(clk), .rst(rstm), .ce(cem), .din(mult), .dout(m_q)
    );

    assign cin_src = (CARRYINSEL == "OPMODE5") ? opmode_q[OP_CIN] : carryin;

    dsp_reg_mux #(.width(1), .enable(CARRYINREG)) u_cinreg (
        .clk(clk), .rst(rstcarryin), .ce(cecarryin), .din(cin_src), .dout(cin_q)
    );

    always_comb begin
        xmux = '0;
        case (xsel_e'(opmode_q[OP_X_HI:OP_X_LO]))
            X_ZERO:  xmux = '0;
            X_M:     xmux = {{dhi{1'b0}}, m_q};
            X_P:     xmux = p_q;
            X_DAB:   xmux = {d_q[dhi-1:0], a1_q, b1_q};
            default: xmux = '0;
        endcase
    end

    always_comb begin
        zmux = '0;
        case (zsel_e'(opmode_q[OP_Z_HI:OP_Z_LO]))
            Z_ZERO:  zmux = '0;
            Z_PCIN:  zmux = pcin;
            Z_P:     zmux = p_q;
            Z_C:     zmux = c_q;
            default: zmux = '0;
        endcase
    end

    // One extra bit so the top bit carries out of add or borrows out of subtract.
    always_comb begin
        if (opmode_q[OP_POST_SUB]) begin
            post = {1'b0, zmux} - ({1'b0, xmux} + {{dataoutwidth{1'b0}}, cin_q});
        end else begin
            post = {1'b0, zmux} + {1'b0, xmux} + {{dataoutwidth{1'b0}}, cin_q};
        end
    end

    dsp_reg_mux #(.width(dataoutwidth), .enable(PREG)) u_preg (
        .clk(clk), .rst(rstp), .ce(cep), .din(post[dataoutwidth-1:0]), .dout(p_q)
    );

    dsp_reg_mux #(.width(1), .enable(CARRYOUTREG)) u_cyoreg (
        .clk(clk), .rst(rstcarryin), .ce(cecarryin), .din(post[dataoutwidth]), .dout(cyo_q)
    );

    assign m         = m_q;
    assign p         = p_q;
    assign pcout     = p_q;
    assign bcout     = b1_q;
    assign carryout  = cyo_q;
    assign carryoutf = cyo_q;

endmodule

// File: tb/tb_dsp_top.sv
// Directed bench for dsp_top: reset, table of opmode vectors, accumulation, stage reset,
// clock-enable hold and pipeline latency.
module tb_dsp_top;

    logic        clk = 1'b0;
    logic        rsta, rstb, rstm, rstp, rstc, rstd, rstcarryin, rstopmode;
    logic        cea, ceb, cem, cep, cec, ced, cecarryin, ceopmode;
    logic [17:0] d, b, bcin, a;
    logic [47:0] c, pcin;
    logic        carryin;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] p, pcout;
    logic [17:0] bcout;
    logic        carryout, carryoutf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  op;
        logic [35:0] m;
        logic [47:0] p;
        logic        co;
        logic [17:0] bc;
    } vec_t;

    vec_t vecs[4];

    dsp_top dut (
        .clk(clk), .rsta(rsta), .rstb(rstb), .rstm(rstm), .rstp(rstp), .rstc(rstc),
        .rstd(rstd), .rstcarryin(rstcarryin), .rstopmode(rstopmode),
        .cea(cea), .ceb(ceb), .cem(cem), .cep(cep), .cec(cec), .ced(ced),
        .cecarryin(cecarryin), .ceopmode(ceopmode),
        .d(d), .b(b), .bcin(bcin), .a(a), .c(c), .pcin(pcin), .carryin(carryin),
        .opmode(opmode), .m(m), .p(p), .pcout(pcout), .bcout(bcout),
        .carryout(carryout), .carryoutf(carryoutf)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        rsta = v; rstb = v; rstm = v; rstp = v; rstc = v; rstd = v;
        rstcarryin = v; rstopmode = v;
    endtask

    // scoreboard
    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{op: 8'hE0, m: 36'd180, p: 48'hFFFF_FFFF_FFFF, co: 1'b1, bc: 18'd12};
        vecs[1] = '{op: 8'hF0, m: 36'd120, p: 48'hFFFF_FFFF_FFFF, co: 1'b1, bc: 18'd8};
        vecs[2] = '{op: 8'h30, m: 36'd480, p: 48'd1,              co: 1'b0, bc: 18'd32};
        vecs[3] = '{op: 8'h35, m: 36'd480, p: 48'd529,            co: 1'b0, bc: 18'd32};

        d = 18'd20; b = 18'd12; bcin = 18'd18; a = 18'd15;
        c = 48'd32; pcin = 48'd48; carryin = 1'b1; opmode = 8'h00;
        cea = 1; ceb = 1; cem = 1; cep = 1; cec = 1; ced = 1; cecarryin = 1; ceopmode = 1;
        set_rst(1'b1);

        // reset state
        tick(2);
        check("rst_p", p, 48'd0);
        check("rst_pcout", pcout, 48'd0);
        check("rst_m", {12'd0, m}, 48'd0);
        check("rst_bcout", {30'd0, bcout}, 48'd0);
        check("rst_carryout", {47'd0, carryout}, 48'd0);
        check("rst_carryoutf", {47'd0, carryoutf}, 48'd0);
        set_rst(1'b0);

        // table of settled opmode results
        for (int i = 0; i < 4; i++) begin
            opmode = vecs[i].op;
            tick(6);
            check($sformatf("vec%0d_m", i), {12'd0, m}, {12'd0, vecs[i].m});
            check($sformatf("vec%0d_p", i), p, vecs[i].p);
            check($sformatf("vec%0d_pcout", i), pcout, vecs[i].p);
            check($sformatf("vec%0d_carryout", i), {47'd0, carryout}, {47'd0, vecs[i].co});
            check($sformatf("vec%0d_carryoutf", i), {47'd0, carryoutf}, {47'd0, vecs[i].co});
            check($sformatf("vec%0d_bcout", i), {30'd0, bcout}, {30'd0, vecs[i].bc});
        end

        // accumulation: opmode register adds one edge before feedback starts
        opmode = 8'h3A;
        tick(1);
        check("acc_opreg", p, 48'd529);
        tick(1);
        check("acc_1", p, 48'd1059);
        tick(1);
        check("acc_2", p, 48'd2119);
        opmode = 8'h3F;
        tick(1);
        check("acc_3", p, 48'd4239);
        tick(1);
        check("dab_c", p, 48'h0140_003C_0041);
        tick(1);
        check("dab_c_hold", pcout, 48'h0140_003C_0041);
        check("dab_c_co", {47'd0, carryout}, 48'd0);

        // stage reset in the middle of accumulation
        opmode = 8'h3A;
        tick(2);
        check("acc_pre_rst", p, 48'h0280_0078_0083);
        rstp = 1'b1; rstm = 1'b1;
        tick(1);
        check("midrst_p", p, 48'd0);
        check("midrst_pcout", pcout, 48'd0);
        check("midrst_m", {12'd0, m}, 48'd0);
        rstp = 1'b0; rstm = 1'b0;
        tick(1);
        check("resume_p1", p, 48'd1);
        check("resume_m", {12'd0, m}, 48'd480);
        tick(1);
        check("resume_p2", p, 48'd3);
        tick(1);
        check("resume_p3", p, 48'd7);

        // clock-enable hold on P
        cep = 1'b0;
        tick(3);
        check("ce_hold", p, 48'd7);
        cep = 1'b1;
        tick(1);
        check("ce_resume", p, 48'd15);

        // a -> p latency: A1, M, P
        opmode = 8'h01;
        tick(6);
        check("lat_a_base", p, 48'd180);
        a = 18'd7;
        tick(2);
        check("lat_a_m", {12'd0, m}, 48'd84);
        check("lat_a_p2", p, 48'd180);
        tick(1);
        check("lat_a_p3", p, 48'd84);

        // d -> p latency: D, B1, M, P
        a = 18'd15;
        opmode = 8'h11;
        tick(6);
        check("lat_d_base", p, 48'd480);
        d = 18'd30;
        tick(3);
        check("lat_d_p3", p, 48'd480);
        tick(1);
        check("lat_d_p4", p, 48'd630);
        check("lat_d_bcout", {30'd0, bcout}, 48'd42);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
